free_list: RTL and testbench
============================

FREE_LIST -- requirements
Module: free_list

Interface
REQ-001 SHALL have parameter PR_COUNT, default 128: total physical registers.
REQ-002 SHALL have parameter BANK_COUNT, default 4: banks; bank of a PR = PR[1:0], bank slot tag = PR[6:2].
REQ-003 SHALL have parameter LOWER_THRESHOLD, default 8: per-bank low-water mark.
REQ-004 SHALL have parameter INIT_ALLOCATED, default 32: PRs 0..INIT_ALLOCATED-1 held by the initial architectural map, absent from the list at reset.
REQ-005 SHALL have port CLK  in  1  clock, rising-edge.
REQ-006 SHALL have port nRST  in  1  reset, asynchronous, active-low.
REQ-007 SHALL have port free_valid  in  1  ROB PR-free queue presents a freed PR.
REQ-008 SHALL have port free_PR  in  7  freed PR.
REQ-009 SHALL have port free_ready  out  1  target bank of free_PR not full.
REQ-010 SHALL have port alloc_valid_by_bank  out  4  bank b has at least one PR.
REQ-011 SHALL have port alloc_PR_by_bank  out  4x7  head PR of bank b.
REQ-012 SHALL have port alloc_ack_by_bank  in  4  rename consumes head of bank b this cycle.
REQ-013 SHALL have port low_by_bank  out  4  bank b count < LOWER_THRESHOLD.
REQ-014 SHALL have port double_free_err  out  1  sticky double-free flag (see Configuration).

Function
REQ-015 SHALL implement each bank as a circular FIFO of PR_COUNT/BANK_COUNT (32) upper_PR entries with 5-bit head, 5-bit tail, and 6-bit count.
REQ-016 SHALL store only upper_PR bits; alloc_PR_by_bank[b] = {head entry, b[1:0]}.
REQ-017 SHALL enqueue when free_valid && free_ready: write free_PR[6:2] at tail of bank free_PR[1:0], tail+1 mod 32, count+1, visible next cycle.
REQ-018 SHALL drive free_ready = (count of bank free_PR[1:0] != 32), combinational from registered count only.
REQ-019 SHALL dequeue bank b when alloc_ack_by_bank[b] && alloc_valid_by_bank[b]: head+1 mod 32, count-1; ack with valid low SHALL be ignored.
REQ-020 SHALL drive alloc_valid_by_bank[b] = (count != 0) and low_by_bank[b] = (count < LOWER_THRESHOLD), both from registered state, no enqueue bypass.
REQ-021 SHALL, on simultaneous enqueue and dequeue in the same bank, advance both pointers and hold count; full bank with simultaneous dequeue SHALL still deassert free_ready (no pass-through).
REQ-022 SHALL accept at most one free and up to four allocs (one per bank) per cycle.
REQ-023 SHALL have zero-cycle alloc latency (head combinational from storage) and one-cycle free-to-alloc latency on an empty bank.

Reset
REQ-024 SHALL, on nRST low, asynchronously set each bank b to contain PRs INIT_ALLOCATED..PR_COUNT-1 with PR[1:0]==b in ascending order: head=0, tail=24, count=24 for defaults.
REQ-025 SHALL reset outputs to: free_ready=1, alloc_valid_by_bank=4'hF, alloc_PR_by_bank[b]=32+b, low_by_bank=0, double_free_err=0.
REQ-026 SHALL abandon any in-flight enqueue/dequeue when reset asserts mid-operation; state after release equals REQ-024.

Configuration
REQ-027 SHALL, with FREE_LIST_DOUBLE_FREE_CHECK_EN defined, keep a PR_COUNT-bit in-list vector (reset: bits INIT_ALLOCATED..PR_COUNT-1 set), set on enqueue, clear on dequeue, and set double_free_err (sticky until reset) on an accepted enqueue whose PR bit is already set; the enqueue SHALL still proceed.
REQ-028 SHALL, without FREE_LIST_DOUBLE_FREE_CHECK_EN, omit the vector and tie double_free_err to 0.

Verification
REQ-029 SHALL cover reset: release nRST -> alloc_PR_by_bank = {35,34,33,32}, alloc_valid=4'hF, count 24 each.
REQ-030 SHALL cover drain: ack bank 2 for 24 cycles -> PRs 34,38,...,126 in order, then alloc_valid_by_bank[2]=0, low_by_bank[2]=1 from count 7 onward.
REQ-031 SHALL cover full: free PRs 1,5,9,...,29 into bank 1 (8 frees) -> count 32, free_ready=0 for free_PR=7'd1.
REQ-032 SHALL cover simultaneous: bank 0 at 32 entries with ack and free_valid (PR 0) same cycle -> free_ready=0, free not accepted, count 31.
REQ-033 SHALL cover wrap: 40 alternating free/ack cycles on bank 3 -> pointers wrap past 31, FIFO order preserved.
REQ-034 SHALL cover double free (macro on): free PR 40 while in list -> double_free_err=1 next cycle, stays 1 until nRST.

Source files
------------

// File: rtl/free_list.sv
// rtl/free_list.sv - banked physical-register free list (optional checker: FREE_LIST_DOUBLE_FREE_CHECK_EN)
module free_list #(
   parameter  int PR_COUNT        = 128,
   parameter  int BANK_COUNT      = 4,
   parameter  int LOWER_THRESHOLD = 8,
   parameter  int INIT_ALLOCATED  = 32,
   localparam int PR_W            = $clog2(PR_COUNT),
   localparam int BANK_W          = $clog2(BANK_COUNT)
) (
   input  logic                       CLK,
   input  logic                       nRST,
   input  logic                       free_valid,
   input  logic [PR_W-1:0]            free_PR,
   output logic                       free_ready,
   output logic [BANK_COUNT-1:0]      alloc_valid_by_bank,
   output logic [BANK_COUNT*PR_W-1:0] alloc_PR_by_bank,
   input  logic [BANK_COUNT-1:0]      alloc_ack_by_bank,
   output logic [BANK_COUNT-1:0]      low_by_bank,
   output logic                       double_free_err
);

   localparam int DEPTH         = PR_COUNT / BANK_COUNT;
   localparam int SLOT_W        = PR_W - BANK_W;
   localparam int PTR_W         = $clog2(DEPTH);
   localparam int CNT_W         = PTR_W + 1;
   localparam int INIT_PER_BANK = INIT_ALLOCATED / BANK_COUNT;
   localparam int FREE_PER_BANK = DEPTH - INIT_PER_BANK;

   localparam logic [CNT_W-1:0] DEPTH_C   = CNT_W'(DEPTH);
   localparam logic [CNT_W-1:0] INIT_CNT  = CNT_W'(FREE_PER_BANK);
   localparam logic [PTR_W-1:0] INIT_TAIL = PTR_W'(FREE_PER_BANK % DEPTH);
   localparam logic [CNT_W-1:0] LOW_C     = CNT_W'(LOWER_THRESHOLD);

   // Per-bank storage holds only the slot tag; the bank number is implied by position.
   logic [SLOT_W-1:0] mem_q   [BANK_COUNT][DEPTH];
   logic [PTR_W-1:0]  head_q  [BANK_COUNT];
   logic [PTR_W-1:0]  head_d  [BANK_COUNT];
   logic [PTR_W-1:0]  tail_q  [BANK_COUNT];
   logic [PTR_W-1:0]  tail_d  [BANK_COUNT];
   logic [CNT_W-1:0]  count_q [BANK_COUNT];
   logic [CNT_W-1:0]  count_d [BANK_COUNT];

   logic [BANK_W-1:0]     enq_bank;
   logic                  enq;
   logic [BANK_COUNT-1:0] deq;

   // Slot i of every bank initially holds the i-th PR above the architectural map.
   function automatic logic [SLOT_W-1:0] init_slot(input int i);
      return (i < FREE_PER_BANK) ? SLOT_W'(INIT_PER_BANK + i) : '0;
   endfunction

   // Readiness looks only at registered count, so a full bank refuses even while draining.
   assign enq_bank   = free_PR[BANK_W-1:0];
   assign free_ready = (count_q[enq_bank] != DEPTH_C);
   assign enq        = free_valid && free_ready;

   // Per-bank status and head presentation straight from registered state.
   always_comb begin
      alloc_valid_by_bank = '0;
      low_by_bank         = '0;
      deq                 = '0;
      alloc_PR_by_bank    = '0;
      for (int b = 0; b < BANK_COUNT; b++) begin
         alloc_valid_by_bank[b]          = (count_q[b] != '0);
         low_by_bank[b]                  = (count_q[b] < LOW_C);
         deq[b]                          = alloc_ack_by_bank[b] && (count_q[b] != '0);
         alloc_PR_by_bank[b*PR_W +: PR_W] = {mem_q[b][head_q[b]], BANK_W'(b)};
      end
   end

   // Pointer and occupancy next-state; simultaneous push and pop leave count unchanged.
   always_comb begin
      for (int b = 0; b < BANK_COUNT; b++) begin
         head_d[b]  = head_q[b];
         tail_d[b]  = tail_q[b];
         count_d[b] = count_q[b];
         if (enq && (enq_bank == BANK_W'(b))) begin
            tail_d[b] = tail_q[b] + 1'b1;
         end
         if (deq[b]) begin
            head_d[b] = head_q[b] + 1'b1;
         end
         case ({enq && (enq_bank == BANK_W'(b)), deq[b]})
            2'b10:   count_d[b] = count_q[b] + 1'b1;
            2'b01:   count_d[b] = count_q[b] - 1'b1;
            default: count_d[b] = count_q[b];
         endcase
      end
   end

   // Pointer and count registers.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         for (int b = 0; b < BANK_COUNT; b++) begin
            head_q[b]  <= '0;
            tail_q[b]  <= INIT_TAIL;
            count_q[b] <= INIT_CNT;
         end
      end else begin
         for (int b = 0; b < BANK_COUNT; b++) begin
            head_q[b]  <= head_d[b];
            tail_q[b]  <= tail_d[b];
            count_q[b] <= count_d[b];
         end
      end
   end

   // Slot storage: preloaded at reset, one write per cycle at the target bank's tail.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         for (int b = 0; b < BANK_COUNT; b++) begin
            for (int i = 0; i < DEPTH; i++) begin
               mem_q[b][i] <= init_slot(i);
            end
         end
      end else if (enq) begin
         mem_q[enq_bank][tail_q[enq_bank]] <= free_PR[PR_W-1:BANK_W];
      end
   end

`ifdef FREE_LIST_DOUBLE_FREE_CHECK_EN
   logic [PR_COUNT-1:0] in_list_q;
   logic [PR_COUNT-1:0] in_list_d;
   logic                dbl_q;
   logic                dbl_d;

   function automatic logic [PR_COUNT-1:0] init_in_list();
      logic [PR_COUNT-1:0] v;
      v = '0;
      for (int p = INIT_ALLOCATED; p < PR_COUNT; p++) begin
         v[p] = 1'b1;
      end
      return v;
   endfunction

   // Membership tracking; a free of a PR already listed is flagged but still enqueued.
   always_comb begin
      in_list_d = in_list_q;
      for (int b = 0; b < BANK_COUNT; b++) begin
         if (deq[b]) begin
            in_list_d[alloc_PR_by_bank[b*PR_W +: PR_W]] = 1'b0;
         end
      end
      if (enq) begin
         in_list_d[free_PR] = 1'b1;
      end
      dbl_d = dbl_q | (enq && in_list_q[free_PR]);
   end

   // Membership vector and sticky error flag.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         in_list_q <= init_in_list();
         dbl_q     <= 1'b0;
      end else begin
         in_list_q <= in_list_d;
         dbl_q     <= dbl_d;
      end
   end

   assign double_free_err = dbl_q;
`else
   assign double_free_err = 1'b0;
`endif

endmodule

// File: tb/tb_free_list.sv
// tb/tb_free_list.sv - scoreboard bench for free_list against a queue-based model
module tb_free_list;

   logic        CLK = 1'b0;
   logic        nRST;
   logic        free_valid;
   logic [6:0]  free_PR;
   logic        free_ready;
   logic [3:0]  alloc_valid_by_bank;
   logic [27:0] alloc_PR_by_bank;
   logic [3:0]  alloc_ack_by_bank;
   logic [3:0]  low_by_bank;
   logic        double_free_err;

   free_list dut (
      .CLK                 (CLK),
      .nRST                (nRST),
      .free_valid          (free_valid),
      .free_PR             (free_PR),
      .free_ready          (free_ready),
      .alloc_valid_by_bank (alloc_valid_by_bank),
      .alloc_PR_by_bank    (alloc_PR_by_bank),
      .alloc_ack_by_bank   (alloc_ack_by_bank),
      .low_by_bank         (low_by_bank),
      .double_free_err     (double_free_err)
   );

   always #5 CLK = ~CLK;

   typedef struct packed {
      logic        rdy;
      logic [3:0]  vld;
      logic [3:0]  low;
      logic [27:0] prs;
      logic        err;
   } exp_t;

   int     checks = 0;
   int     errors = 0;
   int     bq[4][$];
   bit [127:0] inl;
   bit     dbl;
   exp_t   expq[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Model: each bank is a FIFO of whole PR numbers, seeded with PRs 32..127.
   function automatic void model_reset();
      for (int b = 0; b < 4; b++) begin
         bq[b].delete();
         for (int i = 0; i < 24; i++) bq[b].push_back(32 + 4*i + b);
      end
      inl = '0;
      for (int p = 32; p < 128; p++) inl[p] = 1'b1;
      dbl = 1'b0;
   endfunction

   function automatic int pick_free(input int bank);
      for (int p = bank; p < 128; p += 4) if (!inl[p]) return p;
      return -1;
   endfunction

   // Apply one cycle of stimulus, queue what the DUT must show this cycle, then advance the model.
   task automatic drive_cycle(input logic fv, input logic [6:0] fpr, input logic [3:0] ack);
      exp_t e;
      int   fb;
      int   p;
      @(posedge CLK);
      #1;
      free_valid        = fv;
      free_PR           = fpr;
      alloc_ack_by_bank = ack;
      fb    = int'(fpr) % 4;
      e.rdy = (bq[fb].size() != 32);
      e.prs = '0;
      for (int b = 0; b < 4; b++) begin
         e.vld[b] = (bq[b].size() != 0);
         e.low[b] = (bq[b].size() < 8);
         if (bq[b].size() != 0) e.prs[b*7 +: 7] = 7'(bq[b][0]);
      end
      e.err = dbl;
      expq.push_back(e);
      if (nRST) begin
`ifdef FREE_LIST_DOUBLE_FREE_CHECK_EN
         if (fv && e.rdy && inl[fpr]) dbl = 1'b1;
`endif
         for (int b = 0; b < 4; b++) begin
            if (ack[b] && bq[b].size() != 0) begin
               p = bq[b].pop_front();
               inl[p] = 1'b0;
            end
         end
         if (fv && e.rdy) begin
            bq[fb].push_back(int'(fpr));
            inl[fpr] = 1'b1;
         end
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive_cycle(1'b0, 7'd0, 4'b0000);
   endtask

   task automatic rand_cycles(input int n);
      int b;
      int p;
      for (int i = 0; i < n; i++) begin
         b = $urandom_range(0, 3);
         p = ($urandom_range(0, 9) < 8) ? pick_free(b) : -1;
         if (p < 0) p = $urandom_range(0, 127);
         drive_cycle(1'($urandom_range(0, 1)), 7'(p), 4'($urandom_range(0, 15)));
      end
   endtask

   // Monitor: compare the DUT against the oldest queued expectation on each falling edge.
   always @(negedge CLK) begin
      exp_t e;
      if (expq.size() > 0) begin
         e = expq.pop_front();
         chk("free_ready", 32'(free_ready), 32'(e.rdy));
         chk("alloc_valid", 32'(alloc_valid_by_bank), 32'(e.vld));
         chk("low_by_bank", 32'(low_by_bank), 32'(e.low));
         chk("double_free_err", 32'(double_free_err), 32'(e.err));
         for (int b = 0; b < 4; b++) begin
            if (e.vld[b]) chk($sformatf("alloc_PR[%0d]", b), 32'(alloc_PR_by_bank[b*7 +: 7]), 32'(e.prs[b*7 +: 7]));
         end
      end
   end

   initial begin
      int p;
      nRST              = 1'b0;
      free_valid        = 1'b0;
      free_PR           = '0;
      alloc_ack_by_bank = '0;
      model_reset();
      idle(3);
      nRST = 1'b1;

      // Reset state seen after release.
      idle(1);

      // Drain bank 2 completely.
      for (int i = 0; i < 24; i++) drive_cycle(1'b0, 7'd0, 4'b0100);
      idle(2);

      // Fill bank 1 to 32, then offer one more.
      for (int k = 0; k < 8; k++) drive_cycle(1'b1, 7'(1 + 4*k), 4'b0000);
      drive_cycle(1'b1, 7'd1, 4'b0000);
      idle(1);

      // Fill bank 0, then ack and free in the same cycle while full.
      for (int k = 0; k < 8; k++) drive_cycle(1'b1, 7'(4*k), 4'b0000);
      drive_cycle(1'b1, 7'd0, 4'b0001);
      idle(1);

      // Alternate free/ack on bank 3 for 40 cycles so the tail wraps.
      for (int k = 0; k < 40; k++) begin
         if (k % 2 == 0) begin
            p = pick_free(3);
            drive_cycle(1'b1, 7'(p), 4'b0000);
         end else begin
            drive_cycle(1'b0, 7'd0, 4'b1000);
         end
      end
      idle(1);

      // Free PR 40 while it is still listed; flag must stick.
      drive_cycle(1'b1, 7'd40, 4'b0000);
      idle(5);

      rand_cycles(400);

      // Reset in the middle of a busy cycle.
      drive_cycle(1'b1, 7'(pick_free(2) < 0 ? 2 : pick_free(2)), 4'b1111);
      #6;
      nRST = 1'b0;
      model_reset();
      #1;
      chk("async_reset_prs", 32'(alloc_PR_by_bank), 32'({7'd35, 7'd34, 7'd33, 7'd32}));
      chk("async_reset_err", 32'(double_free_err), 32'd0);
      idle(3);
      nRST = 1'b1;
      idle(2);
      rand_cycles(150);
      idle(1);

      for (int i = 0; i < 20 && expq.size() > 0; i++) @(posedge CLK);
      if (expq.size() > 0) begin
         errors++;
         checks++;
         $display("FAIL scoreboard_drain: %0d pending expected 0", expq.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
